fpu_addsub_pipe: RTL and testbench

Parametrised successor of the team's custom-float adder: a handshaked, multi-cycle floating-point add/subtract unit. Format widths are generic, and `op_sub` selects subtract. Rounding is round-to-nearest-even using guard/round/sticky bits. Overflow saturates; underflow and zero results flush to zero. The block sits between the operand register file and the writeback stage; upstream and downstream each use a valid/ready handshake.

---
 rtl/fpu_addsub_pipe.sv | 255 +++++++++++++++++++++++++
 tb/tb_fpu_addsub_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: multi-cycle floating-point add/subtract with valid/ready
// handshakes on both sides. Word layout {sign, exp, mant}, no subnormals,
// round-to-nearest-even, saturating overflow, flush-to-zero underflow.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | in_ready high, waiting for operands
// ALIGN | unpack, classify, shift smaller operand into the G/R/S field
// ADD   | add or subtract aligned significands, pick result sign
// NORM  | one right shift on carry-out, else one left shift per cycle
// ROUND | RNE increment, range checks, pack data_out/status_out
// DONE  | out_valid high, result held until out_ready
module fpu_addsub_pipe #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_A_in,
    input  logic [W-1:0] op_B_in,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic [3:0]   status_out
);

    // Aligned field: {hidden 1, mant, G, R, S}; sum field adds one carry bit.
    localparam int FLD_W = MAN_W + 4;
    localparam int SUM_W = FLD_W + 1;
    localparam int SIG_W = MAN_W + 1;
    // Working exponent has headroom for +1 carries and negative excursions
    // during long left-normalisation.
    localparam int EXW   = EXP_W + 2;
    localparam int SH_W  = $clog2(FLD_W + 1);

    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic signed [EXW-1:0] EXP_SAT  = EXW'((1 << EXP_W) - 1);

    localparam logic [3:0] ST_INEXACT   = 4'b1000;
    localparam logic [3:0] ST_UNDERFLOW = 4'b0100;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0010;
    localparam logic [3:0] ST_EXACT     = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [W-1:0]            a_q, a_d;
    logic [W-1:0]            b_q, b_d;
    logic                    sub_q, sub_d;
    logic [FLD_W-1:0]        big_q, big_d;
    logic [FLD_W-1:0]        small_q, small_d;
    logic                    sign_l_q, sign_l_d;
    logic                    sign_s_q, sign_s_d;
    logic signed [EXW-1:0]   exp_q, exp_d;
    logic                    inf_q, inf_d;
    logic                    inf_sign_q, inf_sign_d;
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic                    sign_q, sign_d;
    logic [W-1:0]            data_q, data_d;
    logic [3:0]              status_q, status_d;

    // Unpack / align helpers
    logic [EXP_W-1:0]        ea, eb, dexp;
    logic                    sgn_a, sgn_b, a_big;
    logic [FLD_W-1:0]        sig_a, sig_b, small_al;
    logic [SH_W-1:0]         shamt;
    logic [2*FLD_W-1:0]      wide_sh;

    // Rounding helpers
    logic                    rnd_g, rnd_r, rnd_s, rnd_lsb, rnd_inc, inexact;
    logic [SIG_W:0]          rnd_sig;
    logic signed [EXW-1:0]   rnd_exp;
    logic [MAN_W-1:0]        rnd_man;

    assign ea    = a_q[MAN_W +: EXP_W];
    assign eb    = b_q[MAN_W +: EXP_W];
    assign sgn_a = a_q[W-1];
    assign sgn_b = b_q[W-1] ^ sub_q;
    assign sig_a = (ea == '0) ? '0 : {1'b1, a_q[MAN_W-1:0], 3'b000};
    assign sig_b = (eb == '0) ? '0 : {1'b1, b_q[MAN_W-1:0], 3'b000};
    assign a_big = (ea >= eb);
    assign dexp  = a_big ? (ea - eb) : (eb - ea);

    // Shifts of the full field width or more leave only the sticky bit.
    assign shamt    = (32'(dexp) >= FLD_W) ? SH_W'(FLD_W) : SH_W'(dexp);
    assign wide_sh  = {(a_big ? sig_b : sig_a), {FLD_W{1'b0}}} >> shamt;
    assign small_al = wide_sh[2*FLD_W-1 -: FLD_W]
                    | {{(FLD_W-1){1'b0}}, |wide_sh[FLD_W-1:0]};

    assign rnd_lsb = sum_q[3];
    assign rnd_g   = sum_q[2];
    assign rnd_r   = sum_q[1];
    assign rnd_s   = sum_q[0];
    assign rnd_inc = rnd_g & (rnd_r | rnd_s | rnd_lsb);
    assign inexact = rnd_g | rnd_r | rnd_s;
    assign rnd_sig = {1'b0, sum_q[FLD_W-1:3]} + {{SIG_W{1'b0}}, rnd_inc};
    assign rnd_exp = exp_q + {{(EXW-1){1'b0}}, rnd_sig[SIG_W]};
    assign rnd_man = rnd_sig[SIG_W] ? rnd_sig[MAN_W:1] : rnd_sig[MAN_W-1:0];

    assign in_ready   = (state_q == S_IDLE) && reset;
    assign out_valid  = (state_q == S_DONE);
    assign data_out   = data_q;
    assign status_out = status_q;

    // Next-state and datapath updates for every phase of the operation.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sub_d      = sub_q;
        big_d      = big_q;
        small_d    = small_q;
        sign_l_d   = sign_l_q;
        sign_s_d   = sign_s_q;
        exp_d      = exp_q;
        inf_d      = inf_q;
        inf_sign_d = inf_sign_q;
        sum_d      = sum_q;
        sign_d     = sign_q;
        data_d     = data_q;
        status_d   = status_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = op_A_in;
                    b_d     = op_B_in;
                    sub_d   = op_sub;
                    state_d = S_ALIGN;
                end
            end

            S_ALIGN: begin
                big_d      = a_big ? sig_a : sig_b;
                small_d    = small_al;
                sign_l_d   = a_big ? sgn_a : sgn_b;
                sign_s_d   = a_big ? sgn_b : sgn_a;
                exp_d      = EXW'(a_big ? ea : eb);
                inf_d      = (ea == EXP_ONES) || (eb == EXP_ONES);
                inf_sign_d = (ea == EXP_ONES) ? sgn_a : sgn_b;
                state_d    = S_ADD;
            end

            S_ADD: begin
                // With equal exponents the "small" operand may be the larger
                // magnitude, so the subtract direction is decided here.
                if (sign_l_q == sign_s_q) begin
                    sum_d  = {1'b0, big_q} + {1'b0, small_q};
                    sign_d = sign_l_q;
                end else if (big_q >= small_q) begin
                    sum_d  = {1'b0, big_q} - {1'b0, small_q};
                    sign_d = sign_l_q;
                end else begin
                    sum_d  = {1'b0, small_q} - {1'b0, big_q};
                    sign_d = sign_s_q;
                end
                state_d = S_NORM;
            end

            S_NORM: begin
                if (inf_q) begin
                    state_d = S_ROUND;
                end else if (sum_q[SUM_W-1]) begin
                    sum_d   = {1'b0, sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + EXW'(1);
                    state_d = S_ROUND;
                end else if (!sum_q[FLD_W-1] && (sum_q != '0)) begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - EXW'(1);
                end else begin
                    state_d = S_ROUND;
                end
            end

            S_ROUND: begin
                if (inf_q) begin
                    data_d   = {inf_sign_q, EXP_ONES, {MAN_W{1'b0}}};
                    status_d = ST_OVERFLOW;
                end else if (sum_q == '0) begin
                    data_d   = '0;
                    status_d = ST_EXACT;
                end else if (rnd_exp >= EXP_SAT) begin
                    data_d   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                    status_d = ST_OVERFLOW;
                end else if (rnd_exp[EXW-1] || (rnd_exp == '0)) begin
                    data_d   = '0;
                    status_d = ST_UNDERFLOW;
                end else begin
                    data_d   = {sign_q, rnd_exp[EXP_W-1:0], rnd_man};
                    status_d = inexact ? ST_INEXACT : ST_EXACT;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; a low reset discards any operation in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            big_q      <= '0;
            small_q    <= '0;
            sign_l_q   <= 1'b0;
            sign_s_q   <= 1'b0;
            exp_q      <= '0;
            inf_q      <= 1'b0;
            inf_sign_q <= 1'b0;
            sum_q      <= '0;
            sign_q     <= 1'b0;
            data_q     <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sub_q      <= sub_d;
            big_q      <= big_d;
            small_q    <= small_d;
            sign_l_q   <= sign_l_d;
            sign_s_q   <= sign_s_d;
            exp_q      <= exp_d;
            inf_q      <= inf_d;
            inf_sign_q <= inf_sign_d;
            sum_q      <= sum_d;
            sign_q     <= sign_d;
            data_q     <= data_d;
            status_q   <= status_d;
        end
    end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Testbench for fpu_addsub_pipe at default widths (EXP_W=6, MAN_W=25).
// Directed cases followed by random operands checked against an exact
// wide-integer reference model with round-to-nearest-even.
module tb_fpu_addsub_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_A_in;
    logic [31:0] op_B_in;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int n_cmp = 0;
    int n_bad = 0;

    fpu_addsub_pipe dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_A_in    (op_A_in),
        .op_B_in    (op_B_in),
        .op_sub     (op_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .status_out (status_out)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact value arithmetic: operands scaled to a common integer grid, then
    // a single RNE rounding to 26 significant bits.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                      output logic [31:0] d, output logic [3:0] st);
        int ea, eb, emin, p, sh, e;
        logic sa, sb, sr, inexact;
        logic [127:0] xa, xb, x, q, rem, half;
        ea = int'(a[30:25]);
        eb = int'(b[30:25]);
        sa = a[31];
        sb = b[31] ^ sub;
        d  = 32'h0;
        st = 4'b0001;
        if (ea == 0 && eb == 0) return;
        xa = (ea == 0) ? 128'd0 : {102'd0, 1'b1, a[24:0]};
        xb = (eb == 0) ? 128'd0 : {102'd0, 1'b1, b[24:0]};
        if (ea == 0)      emin = eb;
        else if (eb == 0) emin = ea;
        else              emin = (ea < eb) ? ea : eb;
        if (ea != 0) xa = xa << (ea - emin);
        if (eb != 0) xb = xb << (eb - emin);
        if (sa == sb) begin
            x = xa + xb; sr = sa;
        end else if (xa >= xb) begin
            x = xa - xb; sr = sa;
        end else begin
            x = xb - xa; sr = sb;
        end
        if (x == 128'd0) return;
        p = 127;
        while (!x[p]) p--;
        e = emin + p - 25;
        if (p > 25) begin
            sh   = p - 25;
            q    = x >> sh;
            rem  = x - (q << sh);
            half = 128'd1 << (sh - 1);
            inexact = (rem != 128'd0);
            if (rem > half || (rem == half && q[0])) q = q + 128'd1;
            if (q[26]) begin
                q = q >> 1;
                e++;
            end
        end else begin
            q = x << (25 - p);
            inexact = 1'b0;
        end
        if (e >= 63) begin
            d  = {sr, 6'h3F, 25'h0};
            st = 4'b0010;
        end else if (e <= 0) begin
            d  = 32'h0;
            st = 4'b0100;
        end else begin
            d  = {sr, e[5:0], q[24:0]};
            st = inexact ? 4'b1000 : 4'b0001;
        end
    endfunction

    // One complete transaction; exp_lat < 0 skips the latency check.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input int hold, input bit early,
                          input logic [31:0] exp_d, input logic [3:0] exp_st, input int exp_lat);
        int guard;
        int lat;
        logic rdy_seen;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        op_A_in  = a;
        op_B_in  = b;
        op_sub   = sub;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid  = 1'b0;
        op_A_in   = $urandom();
        op_B_in   = $urandom();
        op_sub    = 1'($urandom_range(0, 1));
        out_ready = early;
        lat = 0;
        rdy_seen = 1'b0;
        while (out_valid !== 1'b1 && lat < 100) begin
            rdy_seen = rdy_seen | in_ready;
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
        rdy_seen = rdy_seen | in_ready;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready_busy"}, 32'(rdy_seen), 32'd0);
        check({tag, "_data"}, data_out, exp_d);
        check({tag, "_status"}, 32'(status_out), 32'(exp_st));
        if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (early) begin
            @(posedge clock);
            @(negedge clock);
            check({tag, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
            check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
            out_ready = 1'b0;
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clock);
                @(negedge clock);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
                check({tag, "_hold_data"}, data_out, exp_d);
                check({tag, "_hold_status"}, 32'(status_out), 32'(exp_st));
            end
            out_ready = 1'b1;
            @(posedge clock);
            @(negedge clock);
            out_ready = 1'b0;
            check({tag, "_valid_dropped"}, 32'(out_valid), 32'd0);
            check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] a, b, ed;
        logic [3:0]  est;
        logic        sub;
        int          ea, eb, mode, ma, mb;

        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_A_in   = 32'h0;
        op_B_in   = 32'h0;
        op_sub    = 1'b0;
        reset     = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data", data_out, 32'h0);
        check("rst_status", 32'(status_out), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_op("add_one_one",  32'h3E000000, 32'h3E000000, 1'b0, 0, 1'b0, 32'h40000000, 4'b0001, 4);
        run_op("sub_cancel",   32'h3E000000, 32'h3E000000, 1'b1, 0, 1'b0, 32'h00000000, 4'b0001, 4);
        run_op("sub_k25",      32'h3E000001, 32'h3E000000, 1'b1, 0, 1'b0, 32'h0C000000, 4'b0001, 29);
        run_op("rne_tie_even", 32'h3E000000, 32'h0A000000, 1'b0, 0, 1'b0, 32'h3E000000, 4'b1000, 4);
        run_op("rne_tie_odd",  32'h3E000001, 32'h0A000000, 1'b0, 0, 1'b0, 32'h3E000002, 4'b1000, 4);
        run_op("overflow",     32'h7C000000, 32'h7C000000, 1'b0, 0, 1'b0, 32'h7E000000, 4'b0010, 4);
        run_op("underflow",    32'h02000000, 32'h02000001, 1'b1, 0, 1'b0, 32'h00000000, 4'b0100, 29);
        run_op("backpressure", 32'h3E000000, 32'h3E000000, 1'b0, 3, 1'b0, 32'h40000000, 4'b0001, 4);
        run_op("back_to_back", 32'h3E000000, 32'hBE000000, 1'b1, 0, 1'b1, 32'h40000000, 4'b0001, 4);
        run_op("inf_a",        32'h7E000000, 32'h3E000000, 1'b0, 0, 1'b0, 32'h7E000000, 4'b0010, 4);
        run_op("inf_b_sub",    32'h3E000000, 32'h7E000000, 1'b1, 0, 1'b0, 32'hFE000000, 4'b0010, 4);
        run_op("zero_plus_x",  32'h00000000, 32'hBE000005, 1'b0, 0, 1'b0, 32'hBE000005, 4'b0001, 4);

        // Reset pulled mid-NORM of the long cancellation.
        op_A_in  = 32'h3E000001;
        op_B_in  = 32'h3E000000;
        op_sub   = 1'b1;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("mid_norm_busy", 32'(out_valid), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_data", data_out, 32'h0);
        check("midrst_status", 32'(status_out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst_release_in_ready", 32'(in_ready), 32'd1);
        check("midrst_release_valid", 32'(out_valid), 32'd0);
        run_op("post_rst_add", 32'h3E000000, 32'h3E000000, 1'b0, 0, 1'b0, 32'h40000000, 4'b0001, 4);

        for (int n = 0; n < 200; n++) begin
            ea = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 62));
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       eb = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 62));
                1:       eb = ea;
                2:       eb = ea + int'($urandom_range(0, 2)) - 1;
                default: eb = ea - int'($urandom_range(24, 30));
            endcase
            if (eb < 0)  eb = 0;
            if (eb > 62) eb = 62;
            ma = int'($urandom());
            mb = (mode == 1) ? (ma ^ int'($urandom_range(0, 255))) : int'($urandom());
            a   = {1'($urandom_range(0, 1)), 6'(ea), 25'(ma)};
            b   = {1'($urandom_range(0, 1)), 6'(eb), 25'(mb)};
            sub = 1'($urandom_range(0, 1));
            ref_model(a, b, sub, ed, est);
            run_op($sformatf("rand%0d", n), a, b, sub, int'($urandom_range(0, 2)),
                   ($urandom_range(0, 3) == 0), ed, est, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
